// File: rtl/pipeline_control_if.sv
// Hazard/event requests into the pipeline controller and the latch controls it drives.
// The controller uses the master modport; the pipeline datapath uses the slave modport.
interface pipeline_control_if;
  logic       id_load_use;
  logic       ex_mult_start;
  logic       ex_div_start;
  logic       mem_stall;
  logic       mem_exception;

  logic       pc_hold;
  logic       if_id_hold;
  logic       id_ex_hold;
  logic       ex_mem_hold;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       ex_mem_flush;
  logic       mem_wb_flush;
  logic       pc_load_exception;
  logic       ex_accept;
  logic       ex_busy;
  logic       ex_done;
  logic [5:0] remaining;

  modport master (
    input  id_load_use, ex_mult_start, ex_div_start, mem_stall, mem_exception,
    output pc_hold, if_id_hold, id_ex_hold, ex_mem_hold,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           pc_load_exception, ex_accept, ex_busy, ex_done, remaining
  );

  modport slave (
    output id_load_use, ex_mult_start, ex_div_start, mem_stall, mem_exception,
    input  pc_hold, if_id_hold, id_ex_hold, ex_mem_hold,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           pc_load_exception, ex_accept, ex_busy, ex_done, remaining
  );
endinterface

// File: rtl/pipeline_control.sv
// Stall/flush sequencer for the five-stage pipeline: per-latch hold/flush controls plus
// a fixed-length occupancy sequence for multi-cycle multiply/divide in EX.
module pipeline_control #(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 32
) (
  input  logic                clock,
  input  logic                reset,
  pipeline_control_if.master  bus
);

  typedef enum logic {RUN, MULTI} state_t;

  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  state_t     state_q, state_d;
  logic [5:0] count_q, count_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      count_q <= 6'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d               = state_q;
    count_d               = count_q;
    bus.pc_hold           = 1'b0;
    bus.if_id_hold        = 1'b0;
    bus.id_ex_hold        = 1'b0;
    bus.ex_mem_hold       = 1'b0;
    bus.if_id_flush       = 1'b0;
    bus.id_ex_flush       = 1'b0;
    bus.ex_mem_flush      = 1'b0;
    bus.mem_wb_flush      = 1'b0;
    bus.pc_load_exception = 1'b0;
    bus.ex_accept         = 1'b0;
    bus.ex_busy           = 1'b0;
    bus.ex_done           = 1'b0;

    if (reset) begin
      bus.if_id_flush  = 1'b1;
      bus.id_ex_flush  = 1'b1;
      bus.ex_mem_flush = 1'b1;
      bus.mem_wb_flush = 1'b1;
      state_d          = RUN;
      count_d          = 6'd0;
    end else if (bus.mem_exception) begin
      // Exception wins in either state and aborts any multi-cycle op without ex_done.
      bus.ex_busy           = (state_q == MULTI);
      bus.if_id_flush       = 1'b1;
      bus.id_ex_flush       = 1'b1;
      bus.ex_mem_flush      = 1'b1;
      bus.mem_wb_flush      = 1'b1;
      bus.pc_load_exception = 1'b1;
      state_d               = RUN;
      count_d               = 6'd0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.mem_stall) begin
            bus.pc_hold      = 1'b1;
            bus.if_id_hold   = 1'b1;
            bus.id_ex_hold   = 1'b1;
            bus.ex_mem_hold  = 1'b1;
            bus.mem_wb_flush = 1'b1;
          end else if (bus.ex_mult_start || bus.ex_div_start) begin
            bus.ex_accept    = 1'b1;
            bus.pc_hold      = 1'b1;
            bus.if_id_hold   = 1'b1;
            bus.id_ex_hold   = 1'b1;
            bus.ex_mem_flush = 1'b1;
            count_d          = bus.ex_mult_start ? MUL_LOAD : DIV_LOAD;
            state_d          = MULTI;
          end else if (bus.id_load_use) begin
            bus.pc_hold     = 1'b1;
            bus.if_id_hold  = 1'b1;
            bus.id_ex_flush = 1'b1;
          end
        end

        MULTI: begin
          bus.ex_busy = 1'b1;
          // A zero count cannot be reached with legal cycle parameters; treat it as release.
          if (count_q <= 6'd1 && !bus.mem_stall) begin
            bus.ex_done = 1'b1;
            state_d     = RUN;
            count_d     = 6'd0;
          end else begin
            bus.pc_hold    = 1'b1;
            bus.if_id_hold = 1'b1;
            bus.id_ex_hold = 1'b1;
            if (bus.mem_stall) begin
              bus.ex_mem_hold  = 1'b1;
              bus.mem_wb_flush = 1'b1;
            end else begin
              bus.ex_mem_flush = 1'b1;
            end
            if (count_q > 6'd1) begin
              count_d = count_q - 6'd1;
            end
          end
        end

        default: begin
          state_d = RUN;
          count_d = 6'd0;
        end
      endcase
    end
  end

  assign bus.remaining = count_q;

endmodule
